// File: rtl/ss_scroll_ctrl.sv
// ss_scroll_ctrl: scrolls a host-written message of 5-bit glyph codes across a row of seven-segment digits.
//   clk      : sole clock, rising edge
//   rst_n    : asynchronous active-low reset
//   wr_en    : buffer write strobe, honoured only while idle
//   wr_addr  : buffer write address
//   wr_data  : glyph code to write
//   msg_len  : message length in glyphs, clamped to MSG_MAX, sampled at start
//   loop     : 1 = repeat forever, 0 = one pass, sampled at start
//   start    : begin scrolling (level)
//   stop     : abort scrolling, outranks tick and start
//   busy     : high while scrolling
//   done     : one-cycle pulse at the end of a one-shot pass
//   codes    : codes[5*j +: 5] drives digit j, j=0 leftmost
module ss_scroll_ctrl #(
    parameter int DIGITS  = 4,
    parameter int MSG_MAX = 16,
    parameter int DIV     = 50_000_000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [$clog2(MSG_MAX)-1:0] wr_addr,
    input  logic [4:0]                 wr_data,
    input  logic [$clog2(MSG_MAX):0]   msg_len,
    input  logic                       loop,
    input  logic                       start,
    input  logic                       stop,
    output logic                       busy,
    output logic                       done,
    output logic [5*DIGITS-1:0]        codes
);
    localparam int AW = $clog2(MSG_MAX);
    localparam int PW = $clog2(MSG_MAX + DIGITS) + 1;
    localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
    localparam logic [4:0] BLANK = 5'd30;

    typedef enum logic {IDLE, SCROLL} state_t;

    state_t          state;
    logic [4:0]      buf_q [MSG_MAX];
    logic [AW:0]     len_q;
    logic            loop_q;
    logic [CW-1:0]   pre;
    logic [PW-1:0]   p;
    logic [AW:0]     len_eff;
    logic [PW-1:0]   n_len;
    logic            tick;
    logic            last;
    logic [5*DIGITS-1:0] window;

    assign len_eff = msg_len > (AW+1)'(MSG_MAX) ? (AW+1)'(MSG_MAX) : msg_len;
    assign n_len   = PW'(len_q) + PW'(DIGITS);
    assign tick    = pre == CW'(DIV - 1);
    assign last    = p == n_len - PW'(1);

    // Stream position p+j never reaches 2N because p < N and j < DIGITS <= N,
    // so one conditional subtract is a full modulo. The first DIGITS stream
    // slots are leading blanks; the rest index the buffer.
    for (genvar j = 0; j < DIGITS; j++) begin : g_win
        logic [PW-1:0] sum;
        logic [PW-1:0] idx;
        logic [AW-1:0] off;
        assign sum = p + PW'(j);
        assign idx = sum >= n_len ? sum - n_len : sum;
        assign off = AW'(idx - PW'(DIGITS));
        assign window[5*j +: 5] = idx < PW'(DIGITS) ? BLANK : buf_q[off];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            len_q  <= '0;
            loop_q <= 1'b0;
            pre    <= '0;
            p      <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            codes  <= {DIGITS{BLANK}};
            for (int i = 0; i < MSG_MAX; i++) buf_q[i] <= BLANK;
        end else begin
            done  <= 1'b0;
            // codes follow p with one cycle of latency and go blank once idle
            codes <= state == SCROLL ? window : {DIGITS{BLANK}};
            if (wr_en && state == IDLE) buf_q[wr_addr] <= wr_data;
            if (state == IDLE) begin
                pre <= '0;
                p   <= '0;
                if (start && !stop && len_eff != '0) begin
                    state  <= SCROLL;
                    busy   <= 1'b1;
                    len_q  <= len_eff;
                    loop_q <= loop;
                end
            end else if (stop) begin
                state <= IDLE;
                busy  <= 1'b0;
                pre   <= '0;
                p     <= '0;
            end else if (tick) begin
                pre <= '0;
                if (last && !loop_q) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    p     <= '0;
                end else begin
                    p <= last ? '0 : p + PW'(1);
                end
            end else begin
                pre <= pre + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_ss_scroll_ctrl.sv
// tb_ss_scroll_ctrl: directed scoreboard bench for ss_scroll_ctrl (DIV=4 main instance, DIV=1 clamp instance).
module tb_ss_scroll_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [4:0]  wr_data = '0;
    logic [4:0]  msg_len = '0;
    logic        loop = 1'b0;
    logic        start = 1'b0;
    logic        start2 = 1'b0;
    logic        stop = 1'b0;
    logic        busy, done, busy2, done2;
    logic [19:0] codes, codes2;

    int checks = 0;
    int failures = 0;
    string       tagq [$];
    logic [31:0] expq [$];

    always #5 clk = ~clk;

    ss_scroll_ctrl #(.DIGITS(4), .MSG_MAX(16), .DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .msg_len(msg_len), .loop(loop), .start(start), .stop(stop),
        .busy(busy), .done(done), .codes(codes)
    );

    ss_scroll_ctrl #(.DIGITS(4), .MSG_MAX(16), .DIV(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .msg_len(msg_len), .loop(loop), .start(start2), .stop(stop),
        .busy(busy2), .done(done2), .codes(codes2)
    );

    function automatic logic [19:0] pack(input int a, input int b, input int c, input int d);
        return {5'(d), 5'(c), 5'(b), 5'(a)};
    endfunction

    task automatic push(input string t, input logic [31:0] v);
        tagq.push_back(t);
        expq.push_back(v);
    endtask

    task automatic pop(input logic [31:0] obs);
        string t;
        logic [31:0] e;
        checks++;
        if (expq.size() == 0) begin
            failures++;
            $error("FAIL sb_empty observed=%0h expected=none", obs);
        end else begin
            t = tagq.pop_front();
            e = expq.pop_front();
            assert (obs === e) else begin
                failures++;
                $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
            end
        end
    endtask

    task automatic adv(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write(input int a, input int d);
        wr_en = 1'b1; wr_addr = 4'(a); wr_data = 5'(d);
        adv(1);
        wr_en = 1'b0;
    endtask

    // Returns at the negedge just after E0 (the edge that sampled start)
    task automatic start_pass(input int len, input logic lp);
        msg_len = 5'(len); loop = lp; start = 1'b1;
        adv(1);
        start = 1'b0;
    endtask

    initial begin
        logic [19:0] blank4;
        blank4 = pack(30, 30, 30, 30);
        adv(2);
        push("rst_busy", 0);         pop(busy);
        push("rst_done", 0);         pop(done);
        push("rst_codes", blank4);   pop(codes);
        rst_n = 1'b1;
        adv(1);
        write(0, 16); write(1, 14); write(2, 22); write(3, 22); write(4, 0);

        // one-shot pass, N = 9, DIV = 4
        start_pass(5, 1'b0);
        push("os_busy_e0", 1);       pop(busy);
        adv(21);
        push("os_codes_p5", pack(14, 22, 22, 0)); pop(codes);
        adv(14);
        push("os_busy_35", 1);       pop(busy);
        push("os_done_35", 0);       pop(done);
        adv(1);
        push("os_busy_36", 0);       pop(busy);
        push("os_done_36", 1);       pop(done);
        adv(1);
        push("os_done_37", 0);       pop(done);
        push("os_codes_37", blank4); pop(codes);

        // loop pass with a start pulse mid-pass and a write while scrolling
        start_pass(5, 1'b1);
        adv(10);
        start = 1'b1;
        adv(1);
        start = 1'b0;
        adv(25);
        push("lp_done_36", 0);       pop(done);
        push("lp_busy_36", 1);       pop(busy);
        adv(1);
        push("lp_codes_37", blank4); pop(codes);
        adv(4);
        push("lp_codes_41", pack(30, 30, 30, 16)); pop(codes);
        write(0, 5);
        stop = 1'b1;
        adv(1);
        stop = 1'b0;
        push("lp_stop_busy", 0);     pop(busy);
        push("lp_stop_done", 0);     pop(done);

        // stop collides with the tick from p=3
        start_pass(5, 1'b0);
        adv(15);
        stop = 1'b1;
        adv(1);
        stop = 1'b0;
        push("col_busy", 0);         pop(busy);
        push("col_done", 0);         pop(done);
        push("col_codes_p3", pack(30, 16, 14, 22)); pop(codes);
        adv(1);
        push("col_codes_idle", blank4); pop(codes);
        push("col_done2", 0);        pop(done);

        // later pass shows buf[0] unchanged and p restarted from 0
        start_pass(5, 1'b0);
        adv(17);
        push("wr_ign_codes_p4", pack(16, 14, 22, 22)); pop(codes);
        stop = 1'b1;
        adv(1);
        stop = 1'b0;
        adv(1);

        // zero length start is ignored
        start_pass(0, 1'b0);
        push("len0_busy", 0);        pop(busy);
        adv(1);
        push("len0_busy2", 0);       pop(busy);

        // asynchronous reset mid-pass
        start_pass(5, 1'b0);
        adv(22);
        #2 rst_n = 1'b0;
        #1;
        push("arst_busy", 0);        pop(busy);
        push("arst_done", 0);        pop(done);
        push("arst_codes", blank4);  pop(codes);
        @(negedge clk);
        rst_n = 1'b1;
        adv(1);
        start_pass(5, 1'b0);
        adv(21);
        push("arst_buf_blank", blank4); pop(codes);
        adv(20);

        // clamp msg_len to MSG_MAX with DIV = 1: N = 20
        msg_len = 5'd17; loop = 1'b0; start2 = 1'b1;
        adv(1);
        start2 = 1'b0;
        push("clamp_busy_e0", 1);    pop(busy2);
        adv(19);
        push("clamp_busy_19", 1);    pop(busy2);
        push("clamp_done_19", 0);    pop(done2);
        adv(1);
        push("clamp_busy_20", 0);    pop(busy2);
        push("clamp_done_20", 1);    pop(done2);
        adv(1);
        push("clamp_done_21", 0);    pop(done2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
